// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the memory stage, its watchdog and its bus interface:
//   - mem_state_t      : memory stage controller states
//   - TIMEOUT_DEFAULT  : default number of WAIT cycles before an access is abandoned
//   - XLEN             : datapath width
//   - is_word_aligned  : alignment test for word loads and stores
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN            = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // A word access is legal only when the two low address bits are zero.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Bundles the pipeline-side signals and the data-memory handshake of the
// memory stage.
//   master : the memory stage itself
//            (drives wbData/memStall/memErr and the dmem* request signals)
//   slave  : its environment
//            (pipeline operands plus the data memory's response)
// -----------------------------------------------------------------------------
interface memory_stage_if;
    import cpu_pkg::*;

    // pipeline side
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] read2Data;
    logic            memRead;
    logic            memWrite;
    logic [XLEN-1:0] wbData;
    logic            memStall;
    logic            memErr;

    // data memory side
    logic            dmemReq;
    logic            dmemWe;
    logic [XLEN-1:0] dmemAddr;
    logic [XLEN-1:0] dmemWData;
    logic [XLEN-1:0] dmemRData;
    logic            dmemValid;

    modport master (
        input  aluResult, read2Data, memRead, memWrite, dmemRData, dmemValid,
        output wbData, memStall, memErr, dmemReq, dmemWe, dmemAddr, dmemWData
    );

    modport slave (
        output aluResult, read2Data, memRead, memWrite, dmemRData, dmemValid,
        input  wbData, memStall, memErr, dmemReq, dmemWe, dmemAddr, dmemWData
    );

endinterface

// File: rtl/mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts cycles spent waiting for the data memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : zero the counter (asserted on the cycle before WAIT is entered)
//   enable_i   : count one WAIT cycle
//   expired_o  : high during the TIMEOUT-th WAIT cycle
// -----------------------------------------------------------------------------
module mem_watchdog #(
    parameter int TIMEOUT = cpu_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // The first WAIT cycle sees a count of zero, so the TIMEOUT-th sees TIMEOUT-1.
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == LAST);

    // Counter next value: clear wins, then count up; holds once expired.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Pipeline memory stage: issues word loads/stores to a data memory with a
// valid-based handshake, stalls the upstream pipeline while an access is
// outstanding, and selects the writeback value.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : memory_stage_if.master
//                inputs : aluResult, read2Data, memRead, memWrite,
//                         dmemRData, dmemValid
//                outputs: wbData, memStall, memErr (combinational),
//                         dmemReq, dmemWe, dmemAddr, dmemWData (registered)
// -----------------------------------------------------------------------------
module memory_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    memory_stage_if.master       bus
);

    mem_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q,  addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q,    we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q,   err_d;    // set when the access timed out
    logic            req_q,   req_d;

    logic            wd_clear_s;
    logic            wd_enable_s;
    logic            wd_expired_s;
    logic            mem_op_s;
    logic            access_ok_s;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear_s),
        .enable_i  (wd_enable_s),
        .expired_o (wd_expired_s)
    );

    // A legal access is exactly one of read/write to a word-aligned address.
    assign mem_op_s    = bus.memRead | bus.memWrite;
    assign access_ok_s = (bus.memRead ^ bus.memWrite) & is_word_aligned(bus.aluResult);

    assign bus.dmemReq   = req_q;
    assign bus.dmemWe    = we_q;
    assign bus.dmemAddr  = addr_q;
    assign bus.dmemWData = wdata_q;

    // Next-state logic and capture of the access registers.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_d       = 1'b0;
        wd_clear_s  = 1'b0;
        wd_enable_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_ok_s) begin
                    addr_d  = bus.aluResult;
                    wdata_d = bus.read2Data;
                    we_d    = bus.memWrite;
                    err_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                wd_clear_s = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                wd_enable_s = 1'b1;
                // A response on the last allowed cycle still counts as success.
                if (bus.dmemValid) begin
                    if (!we_q) begin
                        rdata_d = bus.dmemRData;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = DONE;
                end else if (wd_expired_s) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                // Always back to IDLE so the retiring instruction is never re-issued.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    // Pipeline-facing outputs; reset forces the pass-through behaviour.
    always_comb begin
        bus.wbData   = bus.aluResult;
        bus.memStall = 1'b0;
        bus.memErr   = 1'b0;
        if (!rst_n) begin
            bus.wbData   = bus.aluResult;
            bus.memStall = 1'b0;
            bus.memErr   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_ok_s) begin
                        bus.memStall = 1'b1;
                    end else if (mem_op_s) begin
                        bus.memErr = 1'b1;
                        bus.wbData = '0;
                    end else begin
                        bus.wbData = bus.aluResult;
                    end
                end
                REQ, WAIT: begin
                    bus.memStall = 1'b1;
                end
                DONE: begin
                    if (we_q) begin
                        bus.wbData = bus.aluResult;
                    end else begin
                        bus.wbData = rdata_q;
                    end
                    bus.memErr = err_q;
                end
                default: begin
                    bus.wbData = bus.aluResult;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// The driver issues instructions and plays the data memory.  For each
// instruction it queues the request and the retirement it expects to see.
// A separate monitor compares those expectations against the DUT whenever it
// issues a request (dmemReq) or retires an instruction (memStall low).
// -----------------------------------------------------------------------------
module tb_memory_stage;

    localparam int TO = 5;

    typedef struct {
        logic [31:0] wb;
        logic        err;
        int          stall;
    } ret_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;

    ret_t exp_q[$];
    req_t req_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    memory_stage_if bus();

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and act as the memory.  lat is the WAIT cycle
    // in which the memory answers; a lat beyond TO means it never answers.
    task automatic run_instr(input bit rd, input bit wr, input logic [31:0] alu,
                             input logic [31:0] wd, input int lat,
                             input logic [31:0] rdat, input bit spur);
        ret_t r;
        req_t q;
        bit   legal;
        bit   tmo;
        int   nwait;
        bus.aluResult = alu;
        bus.read2Data = wd;
        bus.memRead   = rd;
        bus.memWrite  = wr;
        bus.dmemValid = spur;
        bus.dmemRData = $urandom;
        legal = (rd != wr) && (alu[1:0] == 2'b00);
        if (!legal) begin
            r.wb    = (rd || wr) ? 32'd0 : alu;
            r.err   = rd || wr;
            r.stall = 0;
            exp_q.push_back(r);
            step();
            return;
        end
        tmo   = (lat > TO);
        nwait = tmo ? TO : lat;
        q.addr = alu;
        q.we   = wr;
        q.wd   = wd;
        req_q.push_back(q);
        r.wb    = wr ? alu : (tmo ? 32'd0 : rdat);
        r.err   = tmo;
        r.stall = nwait + 2;
        exp_q.push_back(r);
        step();                                   // accept cycle
        bus.dmemValid = spur;                     // stray response while requesting
        bus.dmemRData = $urandom;
        step();
        for (int k = 1; k <= nwait; k++) begin
            bus.dmemValid = (!tmo && k == lat);
            bus.dmemRData = (!tmo && k == lat) ? rdat : $urandom;
            step();
        end
        bus.dmemValid = spur;                     // stray response during retirement
        bus.dmemRData = $urandom;
        step();
    endtask

    // Monitor: checks requests, address/data hold, and every retirement.
    ret_t        e;
    req_t        rq;
    int          stall_cnt = 0;
    bit          prev_req  = 1'b0;
    bit          hold_v    = 1'b0;
    logic [31:0] hold_a;
    logic [31:0] hold_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
            prev_req  = 1'b0;
            hold_v    = 1'b0;
        end else begin
            if (bus.dmemReq) begin
                chk("req_single_cycle", {63'd0, prev_req}, 64'd0);
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr %h expected no request", bus.dmemAddr);
                end else begin
                    rq = req_q.pop_front();
                    chk("req_addr",  {32'd0, bus.dmemAddr},  {32'd0, rq.addr});
                    chk("req_we",    {63'd0, bus.dmemWe},    {63'd0, rq.we});
                    chk("req_wdata", {32'd0, bus.dmemWData}, {32'd0, rq.wd});
                    hold_v = 1'b1;
                    hold_a = rq.addr;
                    hold_d = rq.wd;
                end
            end else if (hold_v) begin
                chk("addr_hold",  {32'd0, bus.dmemAddr},  {32'd0, hold_a});
                chk("wdata_hold", {32'd0, bus.dmemWData}, {32'd0, hold_d});
            end
            prev_req = bus.dmemReq;
            if (bus.memStall) begin
                stall_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got wbData %h expected no retirement", bus.wbData);
                end else begin
                    e = exp_q.pop_front();
                    chk("wbData",      {32'd0, bus.wbData}, {32'd0, e.wb});
                    chk("memErr",      {63'd0, bus.memErr}, {63'd0, e.err});
                    chk("stall_cycles", 64'(stall_cnt),     64'(e.stall));
                end
                stall_cnt = 0;
                hold_v    = 1'b0;
            end
        end
    end

    initial begin
        req_t q;
        rst_n         = 1'b0;
        bus.aluResult = 32'hCAFE_0000;
        bus.read2Data = 32'd0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.dmemRData = 32'd0;
        bus.dmemValid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dmemReq",   {63'd0, bus.dmemReq},   64'd0);
        chk("rst_dmemWe",    {63'd0, bus.dmemWe},    64'd0);
        chk("rst_dmemAddr",  {32'd0, bus.dmemAddr},  64'd0);
        chk("rst_dmemWData", {32'd0, bus.dmemWData}, 64'd0);
        chk("rst_memStall",  {63'd0, bus.memStall},  64'd0);
        chk("rst_memErr",    {63'd0, bus.memErr},    64'd0);
        chk("rst_wbData",    {32'd0, bus.wbData},    64'hCAFE_0000);
        // An access presented during reset must not stall or flag an error
        bus.memRead   = 1'b1;
        bus.aluResult = 32'h0000_0100;
        #1;
        chk("rst_ld_memStall", {63'd0, bus.memStall}, 64'd0);
        chk("rst_ld_wbData",   {32'd0, bus.wbData},   64'h0000_0100);
        bus.memWrite = 1'b1;
        #1;
        chk("rst_both_memErr", {63'd0, bus.memErr},   64'd0);
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        step();
        rst_n = 1'b1;

        // Directed cases
        run_instr(1'b0, 1'b0, 32'h0000_0777, 32'd0, 0, 32'd0, 1'b1);          // pass-through
        run_instr(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);  // fastest load
        run_instr(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 5, 32'd0, 1'b1);  // store, 5 WAIT cycles
        run_instr(1'b1, 1'b0, 32'h0000_0102, 32'd0, 1, 32'd0, 1'b1);          // misaligned
        run_instr(1'b1, 1'b1, 32'h0000_0200, 32'd0, 1, 32'd0, 1'b0);          // read and write
        run_instr(1'b1, 1'b0, 32'h0000_0300, 32'd0, 9, 32'h0000_FFFF, 1'b1);  // load timeout
        run_instr(1'b0, 1'b1, 32'h0000_0304, 32'hA5A5_A5A5, TO + 1, 32'd0, 1'b0); // store timeout
        run_instr(1'b1, 1'b0, 32'h0000_0400, 32'd0, 2, 32'h1111_2222, 1'b0);  // back-to-back
        run_instr(1'b1, 1'b0, 32'h0000_0404, 32'd0, 3, 32'h3333_4444, 1'b0);  //   loads

        // Randomized instruction mix
        for (int i = 0; i < 250; i++) begin
            int          sel;
            logic [31:0] a;
            bit          rd;
            bit          wr;
            sel = $urandom_range(0, 9);
            a   = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            rd = (sel <= 3) || (sel == 8);
            wr = (sel >= 4 && sel <= 6) || (sel == 8);
            run_instr(rd, wr, a, $urandom, $urandom_range(1, TO + 2), $urandom,
                      $urandom_range(0, 1) == 1);
        end

        // Reset while waiting for the memory; its late response is ignored
        q.addr = 32'h0000_0800;
        q.we   = 1'b0;
        q.wd   = 32'd0;
        req_q.push_back(q);
        bus.aluResult = 32'h0000_0800;
        bus.read2Data = 32'd0;
        bus.memRead   = 1'b1;
        bus.memWrite  = 1'b0;
        bus.dmemValid = 1'b0;
        step();
        step();
        rst_n         = 1'b0;
        bus.memRead   = 1'b0;
        bus.aluResult = 32'h55AA_0000;
        @(negedge clk);
        chk("midrst_memStall", {63'd0, bus.memStall}, 64'd0);
        chk("midrst_memErr",   {63'd0, bus.memErr},   64'd0);
        chk("midrst_wbData",   {32'd0, bus.wbData},   64'h55AA_0000);
        chk("midrst_dmemAddr", {32'd0, bus.dmemAddr}, 64'd0);
        step();
        rst_n = 1'b1;
        run_instr(1'b0, 1'b0, 32'h55AA_0004, 32'd0, 0, 32'd0, 1'b0);
        run_instr(1'b0, 1'b0, 32'h55AA_0008, 32'd0, 0, 32'd0, 1'b1);
        run_instr(1'b0, 1'b0, 32'h55AA_000C, 32'd0, 0, 32'd0, 1'b0);
        run_instr(1'b1, 1'b0, 32'h0000_0900, 32'd0, 1, 32'h7777_8888, 1'b0);

        // Everything expected must have been observed
        chk("pending_retire", 64'(exp_q.size()), 64'd0);
        chk("pending_req",    64'(req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
